// File: rtl/tpu_pkg.sv
// Shared TPU definitions: byte width, default buffer depths, the host
// loader state type and the host opcode encodings decoded upstream.
package tpu_pkg;

  localparam int DATA_W        = 8;
  localparam int DEF_W_DEPTH   = 4;   // 2x2 weight array
  localparam int DEF_INP_DEPTH = 4;
  localparam int DEF_INS_DEPTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } loader_state_t;

  // Host opcodes as decoded from the pins by the flag decoder.
  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_FETCH_W   = 3'b001;
  localparam logic [2:0] OP_FETCH_INP = 3'b010;
  localparam logic [2:0] OP_FETCH_INS = 3'b011;
  localparam logic [2:0] OP_START     = 3'b100;

endpackage

// File: rtl/load_buffer.sv
// Byte buffer filled through an auto-incrementing, saturating write pointer.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_wr_en         write i_wr_data at the pointer (dropped when full)
//   i_wr_data       byte to store
//   i_clr_ptr       return the pointer to 0; contents are kept
//   i_rd_addr       read address
//   o_rd_data       combinational read data
//   o_count         entries written since the last pointer clear (0..DEPTH)
module load_buffer
  import tpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_clr_ptr,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [AW:0]       o_count
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_ptr;
  logic              w_full;

  // The pointer stops at DEPTH instead of wrapping, so a full buffer
  // never overwrites entry 0.
  assign w_full = (r_ptr == L_FULL);

  // NOTE: the storage is reset because reads after reset must return 0;
  // this forces flops rather than a RAM macro, acceptable at these depths.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ptr <= '0;
    end else if (i_clr_ptr) begin
      r_ptr <= '0;
    end else if (i_wr_en && !w_full) begin
      // NOTE: non-blocking assignments keep the pointer value used as the
      // write index equal to the pre-edge value.
      r_mem[r_ptr[AW-1:0]] <= i_wr_data;
      r_ptr                <= r_ptr + 1'b1;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];
  assign o_count   = r_ptr;

endmodule

// File: rtl/host_loader.sv
// Host-side load buffer between the pin flag decoder and the TPU core.
// In IDLE, fetch strobes stream bytes into the weight, input and
// instruction buffers; start launches the core (one-cycle core_start) and
// holds the buffers frozen in RUN until core_done. Strobes and data arrive
// already aligned to the same edge, so nothing is re-registered here.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   i_data_in                         host byte qualified by a fetch strobe
//   i_fetch_w/_inp/_ins               write strobe per buffer
//   i_start                           begin a run
//   i_w/inp/ins_rd_addr, o_*_rd_data  combinational core read ports
//   o_ins_count                       instructions loaded
//   o_core_start                      one-cycle launch pulse
//   i_core_done                       core finished (honoured in RUN only)
//   o_busy                            high while in RUN
//   o_overflow                        sticky: a write hit a full buffer
//   o_start_err                       sticky: start with no instructions
module host_loader
  import tpu_pkg::*;
#(
  parameter int W_DEPTH   = DEF_W_DEPTH,
  parameter int INP_DEPTH = DEF_INP_DEPTH,
  parameter int INS_DEPTH = DEF_INS_DEPTH,
  localparam int W_AW     = $clog2(W_DEPTH),
  localparam int INP_AW   = $clog2(INP_DEPTH),
  localparam int INS_AW   = $clog2(INS_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_fetch_w,
  input  logic              i_fetch_inp,
  input  logic              i_fetch_ins,
  input  logic              i_start,
  input  logic [W_AW-1:0]   i_w_rd_addr,
  input  logic [INP_AW-1:0] i_inp_rd_addr,
  input  logic [INS_AW-1:0] i_ins_rd_addr,
  output logic [DATA_W-1:0] o_w_rd_data,
  output logic [DATA_W-1:0] o_inp_rd_data,
  output logic [DATA_W-1:0] o_ins_rd_data,
  output logic [INS_AW:0]   o_ins_count,
  output logic              o_core_start,
  input  logic              i_core_done,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_start_err
);

  localparam logic [W_AW:0]   L_W_FULL   = (W_AW+1)'(W_DEPTH);
  localparam logic [INP_AW:0] L_INP_FULL = (INP_AW+1)'(INP_DEPTH);
  localparam logic [INS_AW:0] L_INS_FULL = (INS_AW+1)'(INS_DEPTH);

  loader_state_t   r_state, w_next_state;
  logic            r_core_start, r_overflow, r_start_err;
  logic [W_AW:0]   w_w_count;
  logic [INP_AW:0] w_inp_count;
  logic [INS_AW:0] w_ins_count;
  logic            w_wr_w, w_wr_inp, w_wr_ins;
  logic            w_launch, w_start_fail, w_drop, w_clr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Strobe priority start > fetch_ins > fetch_inp > fetch_w; only the
  // winning strobe acts, and nothing but core_done acts in RUN.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_next_state = r_state;
    w_wr_w       = 1'b0;
    w_wr_inp     = 1'b0;
    w_wr_ins     = 1'b0;
    w_launch     = 1'b0;
    w_start_fail = 1'b0;
    w_drop       = 1'b0;
    w_clr_ptr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (w_ins_count != '0) begin
            w_next_state = RUN;
            w_launch     = 1'b1;
          end else begin
            w_start_fail = 1'b1;
          end
        end else if (i_fetch_ins) begin
          if (w_ins_count == L_INS_FULL) w_drop = 1'b1;
          else                           w_wr_ins = 1'b1;
        end else if (i_fetch_inp) begin
          if (w_inp_count == L_INP_FULL) w_drop = 1'b1;
          else                           w_wr_inp = 1'b1;
        end else if (i_fetch_w) begin
          if (w_w_count == L_W_FULL) w_drop = 1'b1;
          else                       w_wr_w = 1'b1;
        end
      end
      RUN: begin
        if (i_core_done) begin
          w_next_state = IDLE;
          w_clr_ptr    = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A successful launch clears both sticky flags; it cannot coincide with a
  // drop or a failed start, so the clear needs no priority against them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_start <= 1'b0;
      r_overflow   <= 1'b0;
      r_start_err  <= 1'b0;
    end else begin
      r_core_start <= w_launch;
      if (w_launch) begin
        r_overflow  <= 1'b0;
        r_start_err <= 1'b0;
      end else begin
        if (w_drop)       r_overflow  <= 1'b1;
        if (w_start_fail) r_start_err <= 1'b1;
      end
    end
  end

  load_buffer #(.DEPTH(W_DEPTH)) u_w_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_w),
    .i_wr_data (i_data_in),
    .i_clr_ptr (w_clr_ptr),
    .i_rd_addr (i_w_rd_addr),
    .o_rd_data (o_w_rd_data),
    .o_count   (w_w_count)
  );

  load_buffer #(.DEPTH(INP_DEPTH)) u_inp_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_inp),
    .i_wr_data (i_data_in),
    .i_clr_ptr (w_clr_ptr),
    .i_rd_addr (i_inp_rd_addr),
    .o_rd_data (o_inp_rd_data),
    .o_count   (w_inp_count)
  );

  load_buffer #(.DEPTH(INS_DEPTH)) u_ins_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_ins),
    .i_wr_data (i_data_in),
    .i_clr_ptr (w_clr_ptr),
    .i_rd_addr (i_ins_rd_addr),
    .o_rd_data (o_ins_rd_data),
    .o_count   (w_ins_count)
  );

  assign o_ins_count  = w_ins_count;
  assign o_core_start = r_core_start;
  assign o_busy       = (r_state == RUN);
  assign o_overflow   = r_overflow;
  assign o_start_err  = r_start_err;

endmodule

// File: tb/tb_host_loader.sv
// Self-checking bench for host_loader: directed scenarios plus a randomized
// run compared against a behavioural model of the loader.
module tb_host_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_data_in;
  logic       i_fetch_w, i_fetch_inp, i_fetch_ins, i_start, i_core_done;
  logic [1:0] i_w_rd_addr, i_inp_rd_addr;
  logic [3:0] i_ins_rd_addr;
  logic [7:0] o_w_rd_data, o_inp_rd_data, o_ins_rd_data;
  logic [4:0] o_ins_count;
  logic       o_core_start, o_busy, o_overflow, o_start_err;

  int n_checks = 0;
  int n_errors = 0;

  host_loader dut (
    .clk           (clk),
    .reset         (reset),
    .i_data_in     (i_data_in),
    .i_fetch_w     (i_fetch_w),
    .i_fetch_inp   (i_fetch_inp),
    .i_fetch_ins   (i_fetch_ins),
    .i_start       (i_start),
    .i_w_rd_addr   (i_w_rd_addr),
    .i_inp_rd_addr (i_inp_rd_addr),
    .i_ins_rd_addr (i_ins_rd_addr),
    .o_w_rd_data   (o_w_rd_data),
    .o_inp_rd_data (o_inp_rd_data),
    .o_ins_rd_data (o_ins_rd_data),
    .o_ins_count   (o_ins_count),
    .o_core_start  (o_core_start),
    .i_core_done   (i_core_done),
    .o_busy        (o_busy),
    .o_overflow    (o_overflow),
    .o_start_err   (o_start_err)
  );

  always #50 clk = ~clk;

  // Behavioural model: buffers as arrays, fill levels as integers.
  logic [7:0] m_w [4];
  logic [7:0] m_inp [4];
  logic [7:0] m_ins [16];
  int m_wp, m_ip, m_sp;
  bit m_run, m_cs, m_ovf, m_serr;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_w[i] = 8'h00; m_inp[i] = 8'h00; end
    for (int i = 0; i < 16; i++) m_ins[i] = 8'h00;
    m_wp = 0; m_ip = 0; m_sp = 0;
    m_run = 0; m_cs = 0; m_ovf = 0; m_serr = 0;
  endtask

  task automatic model_edge(input bit st, fi, fp, fw, cd, input logic [7:0] d);
    m_cs = 0;
    if (m_run) begin
      if (cd) begin m_run = 0; m_wp = 0; m_ip = 0; m_sp = 0; end
    end else if (st) begin
      if (m_sp > 0) begin m_run = 1; m_cs = 1; m_ovf = 0; m_serr = 0; end
      else m_serr = 1;
    end else if (fi) begin
      if (m_sp < 16) begin m_ins[m_sp] = d; m_sp++; end else m_ovf = 1;
    end else if (fp) begin
      if (m_ip < 4) begin m_inp[m_ip] = d; m_ip++; end else m_ovf = 1;
    end else if (fw) begin
      if (m_wp < 4) begin m_w[m_wp] = d; m_wp++; end else m_ovf = 1;
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, then release the strobes 1 ns after it. Checks follow at +1 ns.
  task automatic step(input bit st, fi, fp, fw, cd, input logic [7:0] d);
    @(negedge clk);
    i_start = st; i_fetch_ins = fi; i_fetch_inp = fp; i_fetch_w = fw;
    i_core_done = cd; i_data_in = d;
    @(posedge clk);
    model_edge(st, fi, fp, fw, cd, d);
    #1;
    i_start = 0; i_fetch_ins = 0; i_fetch_inp = 0; i_fetch_w = 0; i_core_done = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #120;
    model_reset();
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    n_checks++;
    if (o_core_start !== 1'b0) begin n_errors++; $display("FAIL reset_core_start got %b exp 0", o_core_start); end
    n_checks++;
    if (o_overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b exp 0", o_overflow); end
    n_checks++;
    if (o_start_err !== 1'b0) begin n_errors++; $display("FAIL reset_start_err got %b exp 0", o_start_err); end
    n_checks++;
    if (o_ins_count !== 5'd0) begin n_errors++; $display("FAIL reset_ins_count got %0d exp 0", o_ins_count); end
    n_checks++;
    for (int a = 0; a < 16; a++) begin
      i_ins_rd_addr = 4'(a); i_w_rd_addr = 2'(a); i_inp_rd_addr = 2'(a);
      #1;
      if (o_ins_rd_data !== 8'h00) begin n_errors++; $display("FAIL reset_ins[%0d] got %h exp 00", a, o_ins_rd_data); end
      n_checks++;
      if (a < 4) begin
        if (o_w_rd_data !== 8'h00) begin n_errors++; $display("FAIL reset_w[%0d] got %h exp 00", a, o_w_rd_data); end
        n_checks++;
        if (o_inp_rd_data !== 8'h00) begin n_errors++; $display("FAIL reset_inp[%0d] got %h exp 00", a, o_inp_rd_data); end
        n_checks++;
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_weight_fill();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 8'((i + 1) * 8'h11));
    for (int a = 0; a < 4; a++) begin
      i_w_rd_addr = 2'(a);
      #1;
      if (o_w_rd_data !== 8'((a + 1) * 8'h11)) begin
        n_errors++; $display("FAIL fill_w[%0d] got %h exp %h", a, o_w_rd_data, 8'((a + 1) * 8'h11));
      end
      n_checks++;
    end
    if (o_overflow !== 1'b0) begin n_errors++; $display("FAIL fill_overflow got %b exp 0", o_overflow); end
    n_checks++;
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 1, 0, 8'h55);
    i_w_rd_addr = 2'd3;
    #1;
    if (o_w_rd_data !== 8'h44) begin n_errors++; $display("FAIL ovf_w3 got %h exp 44", o_w_rd_data); end
    n_checks++;
    i_w_rd_addr = 2'd0;
    #1;
    if (o_w_rd_data !== 8'h11) begin n_errors++; $display("FAIL ovf_w0 got %h exp 11", o_w_rd_data); end
    n_checks++;
    if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got %b exp 1", o_overflow); end
    n_checks++;
  endtask

  task automatic test_start_err();
    step(1, 0, 0, 0, 0, 8'h00);
    if (o_start_err !== 1'b1) begin n_errors++; $display("FAIL serr_flag got %b exp 1", o_start_err); end
    n_checks++;
    if (o_core_start !== 1'b0) begin n_errors++; $display("FAIL serr_core_start got %b exp 0", o_core_start); end
    n_checks++;
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL serr_busy got %b exp 0", o_busy); end
    n_checks++;
    if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL serr_ovf_kept got %b exp 1", o_overflow); end
    n_checks++;
  endtask

  task automatic test_run();
    step(0, 1, 0, 0, 0, 8'hA1);
    step(0, 1, 0, 0, 0, 8'hA2);
    if (o_ins_count !== 5'd2) begin n_errors++; $display("FAIL run_load_count got %0d exp 2", o_ins_count); end
    n_checks++;
    step(1, 0, 0, 0, 0, 8'h00);
    if (o_core_start !== 1'b1) begin n_errors++; $display("FAIL run_core_start got %b exp 1", o_core_start); end
    n_checks++;
    if (o_busy !== 1'b1) begin n_errors++; $display("FAIL run_busy got %b exp 1", o_busy); end
    n_checks++;
    if (o_overflow !== 1'b0 || o_start_err !== 1'b0) begin
      n_errors++; $display("FAIL run_flags_cleared got ovf=%b serr=%b exp 0 0", o_overflow, o_start_err);
    end
    n_checks++;
    step(0, 0, 0, 1, 0, 8'h99);
    if (o_core_start !== 1'b0) begin n_errors++; $display("FAIL run_pulse_len got %b exp 0", o_core_start); end
    n_checks++;
    if (o_busy !== 1'b1) begin n_errors++; $display("FAIL run_busy_hold got %b exp 1", o_busy); end
    n_checks++;
    if (o_overflow !== 1'b0) begin n_errors++; $display("FAIL run_fetch_flag got %b exp 0", o_overflow); end
    n_checks++;
    for (int a = 0; a < 4; a++) begin
      i_w_rd_addr = 2'(a);
      #1;
      if (o_w_rd_data !== 8'((a + 1) * 8'h11)) begin
        n_errors++; $display("FAIL run_w_frozen[%0d] got %h exp %h", a, o_w_rd_data, 8'((a + 1) * 8'h11));
      end
      n_checks++;
    end
    step(1, 1, 0, 0, 0, 8'h66);
    if (o_core_start !== 1'b0 || o_ins_count !== 5'd2) begin
      n_errors++; $display("FAIL run_start_ignored got cs=%b cnt=%0d exp 0 2", o_core_start, o_ins_count);
    end
    n_checks++;
    step(0, 0, 0, 0, 1, 8'h00);
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL done_busy got %b exp 0", o_busy); end
    n_checks++;
    if (o_ins_count !== 5'd0) begin n_errors++; $display("FAIL done_count got %0d exp 0", o_ins_count); end
    n_checks++;
    step(0, 1, 0, 0, 0, 8'hB7);
    i_ins_rd_addr = 4'd0;
    #1;
    if (o_ins_rd_data !== 8'hB7) begin n_errors++; $display("FAIL done_ins0 got %h exp B7", o_ins_rd_data); end
    n_checks++;
    i_ins_rd_addr = 4'd1;
    #1;
    if (o_ins_rd_data !== 8'hA2) begin n_errors++; $display("FAIL done_ins1_kept got %h exp A2", o_ins_rd_data); end
    n_checks++;
  endtask

  task automatic test_one_cycle_run();
    step(1, 0, 0, 0, 0, 8'h00);
    if (o_core_start !== 1'b1) begin n_errors++; $display("FAIL short_core_start got %b exp 1", o_core_start); end
    n_checks++;
    step(0, 0, 0, 0, 1, 8'h00);
    if (o_busy !== 1'b0 || o_core_start !== 1'b0) begin
      n_errors++; $display("FAIL short_end got busy=%b cs=%b exp 0 0", o_busy, o_core_start);
    end
    n_checks++;
    if (o_ins_count !== 5'd0) begin n_errors++; $display("FAIL short_count got %0d exp 0", o_ins_count); end
    n_checks++;
  endtask

  task automatic test_priority();
    step(0, 1, 0, 1, 0, 8'h3C);
    i_ins_rd_addr = 4'd0; i_w_rd_addr = 2'd0;
    #1;
    if (o_ins_rd_data !== 8'h3C) begin n_errors++; $display("FAIL prio_ins got %h exp 3C", o_ins_rd_data); end
    n_checks++;
    if (o_w_rd_data !== 8'h11) begin n_errors++; $display("FAIL prio_w_untouched got %h exp 11", o_w_rd_data); end
    n_checks++;
    step(0, 0, 1, 1, 0, 8'h5A);
    i_inp_rd_addr = 2'd0; i_w_rd_addr = 2'd0;
    #1;
    if (o_inp_rd_data !== 8'h5A) begin n_errors++; $display("FAIL prio_inp got %h exp 5A", o_inp_rd_data); end
    n_checks++;
    if (o_w_rd_data !== 8'h11) begin n_errors++; $display("FAIL prio_w_untouched2 got %h exp 11", o_w_rd_data); end
    n_checks++;
    step(1, 1, 0, 0, 0, 8'h77);
    i_ins_rd_addr = 4'd1;
    #1;
    if (o_core_start !== 1'b1 || o_ins_count !== 5'd1) begin
      n_errors++; $display("FAIL prio_start got cs=%b cnt=%0d exp 1 1", o_core_start, o_ins_count);
    end
    n_checks++;
    if (o_ins_rd_data !== m_ins[1]) begin n_errors++; $display("FAIL prio_ins1 got %h exp %h", o_ins_rd_data, m_ins[1]); end
    n_checks++;
    step(0, 0, 0, 0, 1, 8'h00);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
      i_w_rd_addr = 2'($urandom_range(0, 3));
      i_inp_rd_addr = 2'($urandom_range(0, 3));
      i_ins_rd_addr = 4'($urandom_range(0, 15));
      #1;
      if (o_busy !== m_run || o_core_start !== m_cs) begin
        n_errors++; $display("FAIL rand_ctl c=%0d got busy=%b cs=%b exp %b %b", c, o_busy, o_core_start, m_run, m_cs);
      end
      n_checks++;
      if (o_overflow !== m_ovf || o_start_err !== m_serr) begin
        n_errors++; $display("FAIL rand_flags c=%0d got ovf=%b serr=%b exp %b %b", c, o_overflow, o_start_err, m_ovf, m_serr);
      end
      n_checks++;
      if (o_ins_count !== 5'(m_sp)) begin
        n_errors++; $display("FAIL rand_count c=%0d got %0d exp %0d", c, o_ins_count, m_sp);
      end
      n_checks++;
      if (o_w_rd_data !== m_w[i_w_rd_addr] || o_inp_rd_data !== m_inp[i_inp_rd_addr] ||
          o_ins_rd_data !== m_ins[i_ins_rd_addr]) begin
        n_errors++; $display("FAIL rand_read c=%0d got w=%h inp=%h ins=%h exp %h %h %h", c, o_w_rd_data,
                             o_inp_rd_data, o_ins_rd_data, m_w[i_w_rd_addr], m_inp[i_inp_rd_addr], m_ins[i_ins_rd_addr]);
      end
      n_checks++;
    end
  endtask

  task automatic test_reset_mid_run();
    if (m_run) step(0, 0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 0, 0, 8'h42);
    step(1, 0, 0, 0, 0, 8'h00);
    if (o_busy !== 1'b1) begin n_errors++; $display("FAIL midrst_pre_busy got %b exp 1", o_busy); end
    n_checks++;
    #20;
    reset = 1'b1;
    #1;
    model_reset();
    if (o_busy !== 1'b0 || o_core_start !== 1'b0) begin
      n_errors++; $display("FAIL midrst_ctl got busy=%b cs=%b exp 0 0", o_busy, o_core_start);
    end
    n_checks++;
    if (o_ins_count !== 5'd0) begin n_errors++; $display("FAIL midrst_count got %0d exp 0", o_ins_count); end
    n_checks++;
    for (int a = 0; a < 16; a++) begin
      i_ins_rd_addr = 4'(a); i_w_rd_addr = 2'(a); i_inp_rd_addr = 2'(a);
      #1;
      if (o_ins_rd_data !== 8'h00 || o_w_rd_data !== 8'h00 || o_inp_rd_data !== 8'h00) begin
        n_errors++; $display("FAIL midrst_read[%0d] got w=%h inp=%h ins=%h exp 00", a, o_w_rd_data, o_inp_rd_data, o_ins_rd_data);
      end
      n_checks++;
    end
    @(negedge clk);
    reset = 1'b0;
    step(0, 1, 0, 0, 0, 8'hE1);
    i_ins_rd_addr = 4'd0;
    #1;
    if (o_ins_rd_data !== 8'hE1 || o_ins_count !== 5'd1) begin
      n_errors++; $display("FAIL postrst_write got %h cnt=%0d exp E1 1", o_ins_rd_data, o_ins_count);
    end
    n_checks++;
  endtask

  initial begin
    reset = 1'b1;
    i_data_in = '0; i_fetch_w = 0; i_fetch_inp = 0; i_fetch_ins = 0;
    i_start = 0; i_core_done = 0;
    i_w_rd_addr = '0; i_inp_rd_addr = '0; i_ins_rd_addr = '0;
    model_reset();
    test_reset();
    test_weight_fill();
    test_overflow();
    test_start_err();
    test_run();
    test_one_cycle_run();
    test_priority();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
